// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: fetch/decode/execute/memory/writeback sequencing,
// memory handshakes and trapping. Optional performance counters are enabled with RISCV_CTRL_PERF_EN.
module riscv_multicycle_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic        dec_valid,
   input  logic        dec_wb_mem,
   input  logic        dec_rf_wen,
   output logic        ir_we,
   output logic        alu_res_we,
   output logic        dmem_req,
   input  logic        dmem_ack,
   output logic        mdr_we,
   output logic        rf_we,
   output logic        pc_we,
   output logic        trap,
   output logic [1:0]  trap_cause,
`ifdef RISCV_CTRL_PERF_EN
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt,
`endif
   output logic [2:0]  state_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_nxt;
   logic [1:0]       cause_nxt;
   logic             last_wait;

   // Final allowed request cycle; an ack here still wins over the timeout.
   assign last_wait = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign state_o   = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         trap_cause <= 2'b00;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_nxt;
         trap_cause <= cause_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      wait_nxt   = '0;
      cause_nxt  = trap_cause;
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      alu_res_we = 1'b0;
      dmem_req   = 1'b0;
      mdr_we     = 1'b0;
      rf_we      = 1'b0;
      pc_we      = 1'b0;
      trap       = 1'b0;
      case (state)
         IDLE: begin
            if (run) state_nxt = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we     = 1'b1;
               state_nxt = DECODE;
            end else if (last_wait) begin
               state_nxt = TRAP;
               cause_nxt = 2'b10;
            end else begin
               wait_nxt = wait_cnt + CNT_W'(1);
            end
         end
         DECODE: begin
            if (dec_valid) begin
               state_nxt = EXEC;
            end else begin
               state_nxt = TRAP;
               cause_nxt = 2'b01;
            end
         end
         EXEC: begin
            alu_res_we = 1'b1;
            state_nxt  = dec_wb_mem ? MEM : WB;
         end
         MEM: begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
               mdr_we    = 1'b1;
               state_nxt = WB;
            end else if (last_wait) begin
               state_nxt = TRAP;
               cause_nxt = 2'b11;
            end else begin
               wait_nxt = wait_cnt + CNT_W'(1);
            end
         end
         WB: begin
            rf_we     = dec_rf_wen;
            pc_we     = 1'b1;
            state_nxt = run ? FETCH : IDLE;
         end
         TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef RISCV_CTRL_PERF_EN
   // Cycle and retired-instruction counters; both freeze while trapped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (state != IDLE && state != TRAP) cycle_cnt <= cycle_cnt + 32'd1;
         if (state == WB) instret_cnt <= instret_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Drives the register-enable strobes of the PC, instruction register, ALU result register, memory data register and register file.
- Owns the instruction/data memory request handshakes, illegal-instruction trapping and memory-timeout trapping.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles a memory request waits for ack before trapping. Must be >= 1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  core enable; sampled in IDLE and at the end of WB
- imem_req  out  1  instruction fetch request, level
- imem_ack  in  1  fetch data valid this cycle
- dec_valid  in  1  decoder recognised the instruction in IR
- dec_wb_mem  in  1  instruction writes back memory data (load)
- dec_rf_wen  in  1  instruction writes the register file
- ir_we  out  1  load instruction register
- alu_res_we  out  1  latch ALU result
- dmem_req  out  1  data memory request, level
- dmem_ack  in  1  data valid this cycle
- mdr_we  out  1  latch memory data register
- rf_we  out  1  register file write strobe
- pc_we  out  1  PC update strobe (PC mux selected by decoder)
- trap  out  1  sticky fault flag
- trap_cause  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset: async on rst_n low. state=IDLE; every output 0, including trap and trap_cause. Takes effect immediately mid-operation; any in-flight request is dropped.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Encoding 7 is unreachable and recovers to IDLE.
- All strobes (ir_we, alu_res_we, mdr_we, rf_we, pc_we) are single-cycle Moore/Mealy pulses as defined below; otherwise 0.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH:
  - imem_req=1 held until ack.
  - imem_ack=1: ir_we=1 in the same cycle, next state DECODE.
- DECODE: exactly one cycle.
  - dec_valid=0 -> TRAP, cause 01.
  - dec_valid=1 -> EXEC.
- EXEC: one cycle, alu_res_we=1.
  - dec_wb_mem=1 -> MEM; else -> WB.
- MEM:
  - dmem_req=1 held until ack.
  - dmem_ack=1: mdr_we=1 same cycle, next state WB.
- WB: one cycle.
  - rf_we=dec_rf_wen; pc_we=1.
  - Next state: run ? FETCH : IDLE.
- TRAP:
  - trap=1, trap_cause held, all strobes and requests 0.
  - Exits only via reset.
- Timeout:
  - Wait counter, width $clog2(TIMEOUT_CYCLES+1), cleared on entry to FETCH/MEM, increments each cycle without ack.
  - If ack is still absent after TIMEOUT_CYCLES request cycles -> TRAP, cause 10 (FETCH) or 11 (MEM).
  - Ack arriving in the final allowed cycle wins over timeout.
- Ack received while the matching req=0 is ignored.
- run deasserted mid-instruction: the instruction completes through WB, then goes to IDLE. No abort.
- Decoder inputs are only sampled in DECODE/EXEC/WB; they are combinational from IR, stable after ir_we.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU instruction: 4 cycles FETCH->WB.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- Back-to-back: WB->FETCH with no idle cycle while run=1.

Optional Feature:
- Macro: RISCV_CTRL_PERF_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle state!=IDLE and !=TRAP.
  - instret_cnt increments on each WB cycle.
  - Both wrap modulo 2^32 and freeze in TRAP.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- run=1, imem_ack same cycle as req, dec_valid=1, dec_wb_mem=0, dec_rf_wen=1 -> state 1,2,3,5 then 1; ir_we, alu_res_we, rf_we+pc_we pulse once each; 4 cycles per instruction.
- Load, imem 0-wait, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, mdr_we pulses on the ack cycle, WB follows; 8 cycles total.
- dec_valid=0 in DECODE -> next cycle trap=1, trap_cause=01, state_o=6; no rf_we/pc_we; stays in TRAP across 100 cycles with run=1.
- TIMEOUT_CYCLES=4, imem_ack never asserted -> imem_req high exactly 4 cycles, then TRAP cause 10. Repeat with ack in cycle 4 -> DECODE, no trap.
- run dropped during EXEC -> WB completes with pc_we=1, then IDLE; run reasserted -> FETCH next cycle.
- rst_n pulsed low mid-MEM -> all outputs 0 immediately, state_o=0; with RISCV_CTRL_PERF_EN, counters read 0 and instret_cnt=N after N completed instructions.
